// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point ALU pipeline: op encoding and
// the wide-integer round/saturate helpers used by fxp_round_sat.
package fxp_pkg;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_MAC  = 2'b11
    } op_e;

    // Helpers work on a fixed 64-bit signed type; operands are sign-extended into it.
    localparam int unsigned CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    // Round half up, then arithmetic shift right by sh.
    function automatic calc_t round_shift(calc_t x, int unsigned sh);
        calc_t r;
        r = x;
        if (sh > 0) begin
            r = (x + (calc_t'(1) <<< (sh - 1))) >>> sh;
        end
        return r;
    endfunction

    function automatic calc_t sat_max(int unsigned w);
        return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t sat_min(int unsigned w);
        return -(calc_t'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Rounds a signed value (half up, shift right by SHIFT) and saturates it
// to OUT_W bits; ovf flags that clamping occurred.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned SHIFT = 4
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);

    calc_t shifted;

    always_comb begin
        shifted = round_shift(calc_t'(din), SHIFT);
        dout    = shifted[OUT_W-1:0];
        ovf     = 1'b0;
        if (shifted > sat_max(OUT_W)) begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
            ovf  = 1'b1;
        end else if (shifted < sat_min(OUT_W)) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
            ovf  = 1'b1;
        end
    end

endmodule

// File: rtl/fxp_alu_pipe.sv
// Two-stage fixed-point ALU (mult/add/sub/mac) with valid/ready handshake:
// S1 holds the full-precision result, S2 the rounded and saturated one.
module fxp_alu_pipe
    import fxp_pkg::*;
#(
    parameter int unsigned INT_WIDTH  = 4,
    parameter int unsigned FRAC_WIDTH = 4
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [1:0]                          op,
    input  logic [INT_WIDTH+FRAC_WIDTH-1:0]     op_a,
    input  logic [INT_WIDTH+FRAC_WIDTH-1:0]     op_b,
    input  logic                                acc_clr,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [INT_WIDTH+FRAC_WIDTH-1:0]     res,
    output logic                                ovf
);

    localparam int unsigned W  = INT_WIDTH + FRAC_WIDTH;
    localparam int unsigned PW = 2 * W;

    logic                 s1_valid_q, s1_valid_d, s1_shift_q, s1_shift_d, s1_ovf_q, s1_ovf_d;
    logic signed [PW-1:0] s1_val_q, s1_val_d;
    logic                 s2_valid_q, s2_valid_d, ovf_q, ovf_d;
    logic signed [W-1:0]  res_q, res_d, acc_q, acc_d;

    logic                 s1_adv, accept, mac_acc;
    op_e                  op_in;
    logic signed [PW-1:0] a_x, b_x, prod;
    logic signed [W:0]    lin_sum, mac_sum;
    logic signed [W-1:0]  acc_base, prod_rs, acc_new, s2_mult, s2_lin;
    logic                 prod_ovf, acc_ovf, s2_mult_ovf, s2_lin_ovf;

    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = in_valid && in_ready;
    assign op_in    = op_e'(op);
    assign mac_acc  = accept && (op_in == OP_MAC);

    assign a_x      = {{W{op_a[W-1]}}, op_a};
    assign b_x      = {{W{op_b[W-1]}}, op_b};
    assign prod     = a_x * b_x;
    assign lin_sum  = (op_in == OP_SUB) ? ({op_a[W-1], op_a} - {op_b[W-1], op_b})
                                        : ({op_a[W-1], op_a} + {op_b[W-1], op_b});
    assign acc_base = acc_clr ? '0 : acc_q;
    assign mac_sum  = {acc_base[W-1], acc_base} + {prod_rs[W-1], prod_rs};

    // mac finishes in the acceptance cycle so the accumulator can chain back-to-back;
    // S2 then only passes its already-saturated value through.
    fxp_round_sat #(.IN_W(PW), .OUT_W(W), .SHIFT(FRAC_WIDTH)) u_mac_prod (
        .din(prod), .dout(prod_rs), .ovf(prod_ovf));
    fxp_round_sat #(.IN_W(W + 1), .OUT_W(W), .SHIFT(0)) u_mac_acc (
        .din(mac_sum), .dout(acc_new), .ovf(acc_ovf));
    fxp_round_sat #(.IN_W(PW), .OUT_W(W), .SHIFT(FRAC_WIDTH)) u_s2_mult (
        .din(s1_val_q), .dout(s2_mult), .ovf(s2_mult_ovf));
    fxp_round_sat #(.IN_W(PW), .OUT_W(W), .SHIFT(0)) u_s2_lin (
        .din(s1_val_q), .dout(s2_lin), .ovf(s2_lin_ovf));

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_val_d   = s1_val_q;
        s1_shift_d = s1_shift_q;
        s1_ovf_d   = s1_ovf_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        acc_d      = acc_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                case (op_in)
                    OP_MULT: begin
                        s1_val_d   = prod;
                        s1_shift_d = 1'b1;
                        s1_ovf_d   = 1'b0;
                    end
                    OP_MAC: begin
                        s1_val_d   = {{W{acc_new[W-1]}}, acc_new};
                        s1_shift_d = 1'b0;
                        s1_ovf_d   = prod_ovf | acc_ovf;
                    end
                    default: begin
                        s1_val_d   = {{(PW-W-1){lin_sum[W]}}, lin_sum};
                        s1_shift_d = 1'b0;
                        s1_ovf_d   = 1'b0;
                    end
                endcase
            end
        end

        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d = s1_shift_q ? s2_mult : s2_lin;
                ovf_d = s1_ovf_q | (s1_shift_q ? s2_mult_ovf : s2_lin_ovf);
            end
        end

        if (mac_acc) begin
            acc_d = acc_new;
        end else if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_val_q   <= '0;
            s1_shift_q <= 1'b0;
            s1_ovf_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_val_q   <= s1_val_d;
            s1_shift_q <= s1_shift_d;
            s1_ovf_q   <= s1_ovf_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
            acc_q      <= acc_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign res       = res_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fxp_alu_pipe.sv
// Scoreboard bench for fxp_alu_pipe at Q4.4: expected {ovf,res} pushed on
// acceptance, popped and compared by a monitor when a result is delivered.
module tb_fxp_alu_pipe;
    import fxp_pkg::*;

    logic       clk = 1'b0;
    logic       resetn, in_valid, in_ready, acc_clr, out_valid, out_ready, ovf;
    logic [1:0] op;
    logic [7:0] op_a, op_b, res;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_acc    = 0;
    int         n_wait   = 0;
    logic [7:0] m_acc    = '0;
    logic [8:0] exp_q[$];

    fxp_alu_pipe #(.INT_WIDTH(4), .FRAC_WIDTH(4)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op_a(op_a), .op_b(op_b), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .ovf(ovf));

    always #5 clk = ~clk;

    function automatic logic [8:0] model_sat(int v);
        if (v > 127) return 9'h17F;
        if (v < -128) return 9'h180;
        return {1'b0, v[7:0]};
    endfunction

    function automatic logic [8:0] model_alu(logic [1:0] o, logic [7:0] a, logic [7:0] b, logic [7:0] base);
        int sa, sb, sbase;
        logic [8:0] p, s;
        sa    = int'($signed(a));
        sb    = int'($signed(b));
        sbase = int'($signed(base));
        p = model_sat((sa * sb + 8) >>> 4);
        case (o)
            2'b00:   s = p;
            2'b01:   s = model_sat(sa + sb);
            2'b10:   s = model_sat(sa - sb);
            default: begin
                s = model_sat(sbase + int'($signed(p[7:0])));
                s[8] = s[8] | p[8];
            end
        endcase
        return s;
    endfunction

    task automatic monitor();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (resetn && out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_unexpected: got res=%h ovf=%b, required no result", res, ovf);
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf, res} !== e) begin
                        n_fail++;
                        $display("FAIL scoreboard_result: got res=%h ovf=%b, required res=%h ovf=%b",
                                 res, ovf, e[7:0], e[8]);
                    end
                end
            end
        end
    endtask

    // Called at a negedge; holds the beat until accepted, returns at the next negedge.
    task automatic send(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic clr, input logic [8:0] e);
        int unsigned n = 0;
        in_valid = 1'b1; op = o; op_a = a; op_b = b; acc_clr = clr;
        #1;
        while (!in_ready && n < 50) begin
            if (clr) m_acc = '0;
            n_wait++;
            n++;
            @(negedge clk);
            #1;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end else begin
            exp_q.push_back(e);
            n_acc++;
            if (o == OP_MAC) m_acc = e[7:0];
            else if (clr) m_acc = '0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0; acc_clr = 1'b0;
        op = 2'($urandom_range(0, 3)); op_a = 8'($urandom); op_b = 8'($urandom);
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b1; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
        op = '0; op_a = '0; op_b = '0;
        #1 resetn = 1'b0;
        #1;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        if (res !== 8'h00) begin n_fail++; $display("FAIL reset_res: got %h, required 00", res); end
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_mult();
        send(OP_MULT, 8'h18, 8'h20, 1'b0, 9'h030);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mult_latency_early: out_valid=%b one cycle after accept, required 0", out_valid); end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mult_latency_two: out_valid=%b two cycles after accept, required 1", out_valid); end
        @(negedge clk);
        send(OP_MULT, 8'h01, 8'h08, 1'b0, 9'h001);
        send(OP_MULT, 8'h70, 8'h20, 1'b0, 9'h17F);
        send(OP_MULT, 8'hE8, 8'h20, 1'b0, model_alu(OP_MULT, 8'hE8, 8'h20, 8'h00));
        idle();
        wait_drain();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL mult_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_add_sub();
        send(OP_ADD, 8'h70, 8'h20, 1'b0, 9'h17F);
        send(OP_SUB, 8'h80, 8'h10, 1'b0, 9'h180);
        send(OP_ADD, 8'hF0, 8'h10, 1'b0, 9'h000);
        send(OP_SUB, 8'h10, 8'h30, 1'b0, model_alu(OP_SUB, 8'h10, 8'h30, 8'h00));
        idle();
        wait_drain();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL add_sub_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_mac();
        n_wait = 0;
        send(OP_MAC, 8'h10, 8'h10, 1'b1, 9'h010);
        send(OP_MAC, 8'h10, 8'h10, 1'b0, 9'h020);
        send(OP_MAC, 8'h10, 8'h10, 1'b0, 9'h030);
        idle();
        n_checks++;
        if (n_wait != 0) begin n_fail++; $display("FAIL mac_chain_stall: %0d stall cycles, required 0", n_wait); end
        in_valid = 1'b0; acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0; m_acc = '0;
        send(OP_MAC, 8'h10, 8'h10, 1'b0, 9'h010);
        send(OP_ADD, 8'h40, 8'h40, 1'b0, model_alu(OP_ADD, 8'h40, 8'h40, 8'h00));
        send(OP_MAC, 8'h40, 8'h40, 1'b0, model_alu(OP_MAC, 8'h40, 8'h40, m_acc));
        send(OP_MAC, 8'hF0, 8'h10, 1'b0, model_alu(OP_MAC, 8'hF0, 8'h10, m_acc));
        idle();
        wait_drain();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL mac_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        n_acc = 0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [7:0] a;
                    a = 8'(8'h20 * i);
                    send(OP_ADD, a, 8'h30, 1'b0, model_alu(OP_ADD, a, 8'h30, 8'h00));
                end
                idle();
            end
            begin
                logic [7:0] held;
                @(negedge clk);
                @(negedge clk);
                #1;
                n_checks += 2;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
                if (n_acc != 2) begin n_fail++; $display("FAIL stall_accepted: got %0d beats, required 2", n_acc); end
                held = res;
                @(negedge clk);
                #1;
                n_checks += 2;
                if (res !== held) begin n_fail++; $display("FAIL stall_res_hold: got %h, required %h", res, held); end
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: got %b, required 1", out_valid); end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain();
        n_checks += 2;
        if (n_acc != 6) begin n_fail++; $display("FAIL b2b_accepted: got %0d, required 6", n_acc); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        send(OP_MAC, 8'h10, 8'h10, 1'b1, 9'h010);
        send(OP_MAC, 8'h10, 8'h10, 1'b0, 9'h020);
        resetn = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b, required 0", out_valid); end
        exp_q.delete();
        m_acc = '0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_stale: out_valid=%b at cycle %0d, required 0", out_valid, i); end
            @(negedge clk);
        end
        send(OP_MAC, 8'h10, 8'h10, 1'b0, 9'h010);
        idle();
        wait_drain();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midreset_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_random();
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [1:0] o;
                    logic [7:0] a, b;
                    logic       clr;
                    o   = 2'($urandom_range(0, 3));
                    a   = 8'($urandom);
                    b   = 8'($urandom);
                    clr = ($urandom_range(0, 3) == 0);
                    send(o, a, b, clr, model_alu(o, a, b, clr ? 8'h00 : m_acc));
                end
                idle();
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    initial begin
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog expired");
            end
        join_none
        test_reset();
        test_mult();
        test_add_sub();
        test_mac();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fxp_alu_pipe.md
FXP_ALU_PIPE -- requirements
Module: fxp_alu_pipe

Interface
REQ-001 SHALL have parameter INT_WIDTH, default 4, meaning integer bits including sign.
REQ-002 SHALL have parameter FRAC_WIDTH, default 4, meaning fraction bits; W = INT_WIDTH+FRAC_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port op  input  2  operation: 00 mult, 01 add, 10 sub, 11 mac.
REQ-008 SHALL have ports op_a, op_b  input  W  signed Q(INT_WIDTH).(FRAC_WIDTH) operands.
REQ-009 SHALL have port acc_clr  input  1  zero the accumulator.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port res  output  W  signed Q result, same format as operands.
REQ-013 SHALL have port ovf  output  1  result was saturated; qualified by out_valid.

Function
REQ-014 SHALL accept a beat when in_valid && in_ready; deliver a result when out_valid && out_ready.
REQ-015 SHALL be a 2-stage pipeline: S1 full-precision compute, S2 round/saturate; latency is exactly 2 cycles from acceptance to out_valid when out_ready is held high.
REQ-016 SHALL set in_ready = !S1_valid || S1 advances; S1 advances when !S2_valid || out_ready. Full throughput is one beat per cycle, with no combinational path from in_valid to in_ready.
REQ-017 SHALL hold res, ovf and out_valid stable while out_valid && !out_ready, with no beat lost or duplicated.
REQ-018 add/sub SHALL compute a W+1-bit exact sum/difference, then saturate to W bits.
REQ-019 mult SHALL compute the 2W-bit exact product, add 2^(FRAC_WIDTH-1) (round half up), arithmetic-shift right by FRAC_WIDTH, then saturate to W bits.
REQ-020 Saturation bounds SHALL be -2^(W-1) and 2^(W-1)-1 raw. ovf=1 iff clamping occurred.
REQ-021 mac SHALL compute acc_new = sat(acc_base + rounded product), where acc_base = 0 if acc_clr else acc. Output res = acc_new, and the W-bit acc register SHALL update in the acceptance cycle, so back-to-back macs chain without stalls.
REQ-022 SHALL clear acc to 0 when acc_clr is asserted without an accepted mac beat (with in_valid low or a non-mac op). Non-mac ops SHALL NOT change acc.
REQ-023 SHALL ignore op, op_a, op_b and acc_clr on cycles with no acceptance, except as given in REQ-022.
REQ-024 mac ovf SHALL reflect saturation of the product rounding or of the accumulation.

Reset
REQ-025 On resetn low, SHALL asynchronously clear S1/S2 valid, out_valid=0, res=0, ovf=0, acc=0, and in_ready SHALL read 1 once resetn is high.
REQ-026 A reset asserted mid-operation SHALL discard all in-flight beats, and the first result after reset SHALL come from a post-reset beat.

Structure
REQ-027 SHALL place the op encoding enum (OP_MULT, OP_ADD, OP_SUB, OP_MAC) and the saturation/round helper functions in package fxp_pkg.
REQ-028 SHALL put round-and-saturate in sub-module fxp_round_sat (input width, output width and shift as parameters), used by S2 and by the mac accumulate path.

Verification (Q4.4 defaults)
REQ-029 mult 0x18 * 0x20 (1.5*2.0) -> res 0x30, ovf 0, out_valid exactly 2 cycles after acceptance.
REQ-030 mult 0x01 * 0x08 -> res 0x01 (round half up), ovf 0; mult 0x70 * 0x20 -> res 0x7F, ovf 1.
REQ-031 add 0x70 + 0x20 -> 0x7F, ovf 1; sub 0x80 - 0x10 -> 0x80, ovf 1; add 0xF0 + 0x10 -> 0x00, ovf 0.
REQ-032 mac 0x10*0x10 with acc_clr, then two more without -> res 0x10, 0x20, 0x30 on consecutive cycles. A following acc_clr alone followed by a mac of 0x10*0x10 -> res 0x10.
REQ-033 Offer 6 back-to-back adds with out_ready low for 4 cycles: in_ready drops after 2 accepted beats, all 6 results are delivered in order, and res stays unchanged while stalled.
REQ-034 Assert resetn low while 2 beats are in flight -> out_valid 0 immediately; after release, acc=0 and no stale result appears.
